// File: rtl/logic_gate_unit_pkg.sv
// Shared opcodes and the width-agnostic bitwise operation used by logic_gate_unit.
// Optional completed-transaction counter is enabled by LOGIC_GATE_UNIT_OPCNT_EN.
package logic_gate_pkg;

   localparam int MAX_W = 64;

   localparam logic [2:0] OP_AND   = 3'd0;
   localparam logic [2:0] OP_OR    = 3'd1;
   localparam logic [2:0] OP_XOR   = 3'd2;
   localparam logic [2:0] OP_NAND  = 3'd3;
   localparam logic [2:0] OP_NOR   = 3'd4;
   localparam logic [2:0] OP_XNOR  = 3'd5;
   localparam logic [2:0] OP_NOT_A = 3'd6;
   localparam logic [2:0] OP_PASS  = 3'd7;

   // Operates on a max-width vector; callers truncate to their own WIDTH.
   function automatic logic [MAX_W-1:0] lgu_compute(input logic [MAX_W-1:0] a,
                                                    input logic [MAX_W-1:0] b,
                                                    input logic [2:0]       op);
      logic [MAX_W-1:0] y;
      case (op)
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_XOR:   y = a ^ b;
         OP_NAND:  y = ~(a & b);
         OP_NOR:   y = ~(a | b);
         OP_XNOR:  y = ~(a ^ b);
         OP_NOT_A: y = ~a;
         default:  y = a;
      endcase
      return y;
   endfunction

endpackage

// File: rtl/logic_gate_unit_if.sv
// Producer/consumer handshake bundle for logic_gate_unit.
// op_count is only live when LOGIC_GATE_UNIT_OPCNT_EN is defined.
interface logic_gate_unit_if #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [2:0]       in_op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_y;
   logic             out_zero;
   logic             out_ones;
   logic             out_parity;
   logic [CNT_W-1:0] op_count;

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_y, out_zero, out_ones, out_parity, op_count
   );

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_y, out_zero, out_ones, out_parity, op_count
   );
endinterface

// File: rtl/logic_gate_unit_pipe_stage.sv
// Generic valid/ready register slice; data only loads on an actual transfer.
// Part of logic_gate_unit (optional counter macro LOGIC_GATE_UNIT_OPCNT_EN lives in the top).
module lgu_pipe_stage #(
   parameter int                DATA_W  = 8,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              up_valid,
   output logic              up_ready,
   input  logic [DATA_W-1:0] up_data,
   output logic              dn_valid,
   input  logic              dn_ready,
   output logic [DATA_W-1:0] dn_data
);

   assign up_ready = !dn_valid || dn_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dn_valid <= 1'b0;
         dn_data  <= RST_VAL;
      end else begin
         if (up_ready) dn_valid <= up_valid;
         if (up_valid && up_ready) dn_data <= up_data;
      end
   end

endmodule

// File: rtl/logic_gate_unit.sv
// Two-stage pipelined bitwise logic unit with registered zero/ones/parity flags.
// Define LOGIC_GATE_UNIT_OPCNT_EN to enable the wrapping output-transfer counter.
module logic_gate_unit
   import logic_gate_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input logic             sys_clk,
   input logic             sys_rst,
   logic_gate_unit_if.slave bus
);

   localparam int S1_W = 3 + 2*WIDTH;
   localparam int S2_W = WIDTH + 3;
   // S2 reset image: y = 0, zero = 1, ones = 0, parity = 0
   localparam logic [S2_W-1:0] S2_RST = S2_W'(3'b100);

   logic             in_ready;
   logic             s1_valid;
   logic [S1_W-1:0]  s1_data;
   logic             s2_in_ready;
   logic             s2_valid;
   logic [S2_W-1:0]  s2_data;
   logic [2:0]       s1_op;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [WIDTH-1:0] y_next;
   logic [S2_W-1:0]  s2_next;

   lgu_pipe_stage #(.DATA_W(S1_W)) u_s1 (
      .clk      (sys_clk),
      .rst      (sys_rst),
      .up_valid (bus.in_valid),
      .up_ready (in_ready),
      .up_data  ({bus.in_op, bus.in_a, bus.in_b}),
      .dn_valid (s1_valid),
      .dn_ready (s2_in_ready),
      .dn_data  (s1_data)
   );

   assign s1_op = s1_data[S1_W-1 -: 3];
   assign s1_a  = s1_data[2*WIDTH-1 -: WIDTH];
   assign s1_b  = s1_data[WIDTH-1:0];

   always_comb begin
      y_next  = WIDTH'(lgu_compute(MAX_W'(s1_a), MAX_W'(s1_b), s1_op));
      s2_next = {y_next, ~|y_next, &y_next, ^y_next};
   end

   lgu_pipe_stage #(.DATA_W(S2_W), .RST_VAL(S2_RST)) u_s2 (
      .clk      (sys_clk),
      .rst      (sys_rst),
      .up_valid (s1_valid),
      .up_ready (s2_in_ready),
      .up_data  (s2_next),
      .dn_valid (s2_valid),
      .dn_ready (bus.out_ready),
      .dn_data  (s2_data)
   );

   assign bus.in_ready   = in_ready;
   assign bus.out_valid  = s2_valid;
   assign bus.out_y      = s2_data[S2_W-1 -: WIDTH];
   assign bus.out_zero   = s2_data[2];
   assign bus.out_ones   = s2_data[1];
   assign bus.out_parity = s2_data[0];

`ifdef LOGIC_GATE_UNIT_OPCNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)                         cnt_q <= '0;
      else if (s2_valid && bus.out_ready)  cnt_q <= cnt_q + CNT_W'(1);
   end

   assign bus.op_count = cnt_q;
`else
   assign bus.op_count = '0;
`endif

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed and randomised checks for logic_gate_unit with a negedge scoreboard.
// op_count expectations follow LOGIC_GATE_UNIT_OPCNT_EN.
module tb_logic_gate_unit;
   import logic_gate_pkg::*;

   localparam int W  = 8;
   localparam int CW = 16;

   logic sys_clk = 1'b0;
   logic sys_rst;
   always #5 sys_clk = ~sys_clk;

   logic_gate_unit_if #(.WIDTH(W), .CNT_W(CW)) bus ();

   logic_gate_unit #(.WIDTH(W), .CNT_W(CW)) dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a | b;
         3'd2:    return a ^ b;
         3'd3:    return ~(a & b);
         3'd4:    return ~(a | b);
         3'd5:    return ~(a ^ b);
         3'd6:    return ~a;
         default: return a;
      endcase
   endfunction

   function automatic logic [63:0] exp_cnt(input int n);
`ifdef LOGIC_GATE_UNIT_OPCNT_EN
      return 64'(n % (2**CW));
`else
      return 64'(n - n);
`endif
   endfunction

   // scoreboard: expected {y, zero, ones, parity} in issue order
   logic [W+2:0] sb[$];
   int xfer_cnt = 0;

   always @(negedge sys_clk) begin
      logic [W-1:0] y;
      logic [W+2:0] e;
      if (sys_rst) begin
         sb.delete();
         xfer_cnt = 0;
      end else begin
         if (bus.in_valid && bus.in_ready) begin
            y = ref_op(bus.in_a, bus.in_b, bus.in_op);
            sb.push_back({y, ~|y, &y, ^y});
         end
         if (bus.out_valid && bus.out_ready) begin
            xfer_cnt++;
            if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
            else begin
               e = sb.pop_front();
               chk("sb_result", 64'({bus.out_y, bus.out_zero, bus.out_ones, bus.out_parity}), 64'(e));
            end
         end
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
      bus.in_valid = 1'b1; bus.in_a = a; bus.in_b = b; bus.in_op = op;
      tick();
      bus.in_valid = 1'b0;
      tick();
   endtask

   logic [W-1:0] sweep_exp [8];
   logic [W-1:0] held_y;
   int acc, nxt, issued, cyc;
   bit drained;

   initial begin
      sweep_exp[0] = 8'hC0; sweep_exp[1] = 8'hFC; sweep_exp[2] = 8'h3C; sweep_exp[3] = 8'h3F;
      sweep_exp[4] = 8'h03; sweep_exp[5] = 8'hC3; sweep_exp[6] = 8'h0F; sweep_exp[7] = 8'hF0;

      sys_rst = 1'b1;
      bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0; bus.out_ready = 1'b0;
      repeat (2) tick();
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_y", 64'(bus.out_y), 64'd0);
      chk("rst_zero", 64'(bus.out_zero), 64'd1);
      chk("rst_ones", 64'(bus.out_ones), 64'd0);
      chk("rst_parity", 64'(bus.out_parity), 64'd0);
      chk("rst_op_count", 64'(bus.op_count), 64'd0);
      sys_rst = 1'b0;
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

      // opcode sweep, back to back
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (i < 8) begin
            bus.in_valid = 1'b1; bus.in_a = 8'hF0; bus.in_b = 8'hCC; bus.in_op = 3'(i);
            chk($sformatf("sweep_in_ready%0d", i), 64'(bus.in_ready), 64'd1);
         end else bus.in_valid = 1'b0;
         tick();
         if (i >= 1 && i <= 8) begin
            chk($sformatf("sweep_valid%0d", i-1), 64'(bus.out_valid), 64'd1);
            chk($sformatf("sweep_y%0d", i-1), 64'(bus.out_y), 64'(sweep_exp[i-1]));
         end
      end
      chk("sweep_idle", 64'(bus.out_valid), 64'd0);

      // flags
      send_one(8'h00, 8'h5A, OP_PASS);
      chk("flag0_y", 64'(bus.out_y), 64'h00);
      chk("flag0_zo", 64'({bus.out_zero, bus.out_ones, bus.out_parity}), 64'b100);
      send_one(8'h00, 8'h00, OP_NAND);
      chk("flag1_y", 64'(bus.out_y), 64'hFF);
      chk("flag1_zo", 64'({bus.out_zero, bus.out_ones, bus.out_parity}), 64'b010);
      send_one(8'h01, 8'h00, OP_PASS);
      chk("flag2_y", 64'(bus.out_y), 64'h01);
      chk("flag2_zo", 64'({bus.out_zero, bus.out_ones, bus.out_parity}), 64'b001);
      tick();
      chk("flag_drained", 64'(bus.out_valid), 64'd0);

      // backpressure: only two transactions fit
      bus.out_ready = 1'b0;
      acc = 0; nxt = 1;
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1; bus.in_a = 8'(nxt); bus.in_b = 8'h0F; bus.in_op = OP_XOR;
         if (bus.in_ready) begin acc++; nxt++; end
         tick();
      end
      chk("bp_accepted", 64'(acc), 64'd2);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      chk("bp_out_y", 64'(bus.out_y), 64'h0E);
      held_y = bus.out_y;
      bus.in_valid = 1'b0;
      repeat (2) tick();
      chk("bp_stable", 64'(bus.out_y), 64'(held_y));
      bus.out_ready = 1'b1;
      tick();
      chk("bp_second_y", 64'(bus.out_y), 64'h0D);
      chk("bp_second_v", 64'(bus.out_valid), 64'd1);
      tick();
      chk("bp_empty", 64'(bus.out_valid), 64'd0);

      // randomised valid/ready traffic
      issued = 0; cyc = 0;
      while (issued < 400 && cyc < 4000) begin
         bus.in_valid  = ($urandom_range(0, 3) != 0);
         bus.in_a      = 8'($urandom);
         bus.in_b      = 8'($urandom);
         bus.in_op     = 3'($urandom_range(0, 7));
         bus.out_ready = ($urandom_range(0, 2) != 0);
         if (bus.in_valid && bus.in_ready) issued++;
         tick();
         cyc++;
      end
      chk("rand_issued", 64'(issued), 64'd400);
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      drained = 1'b0;
      for (int i = 0; i < 20 && !drained; i++) begin
         tick();
         drained = (sb.size() == 0) && !bus.out_valid;
      end
      chk("rand_drain", 64'(drained), 64'd1);
      chk("op_count_total", 64'(bus.op_count), exp_cnt(xfer_cnt));

      // async reset with both stages full
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_a = 8'h55; bus.in_b = 8'hAA; bus.in_op = OP_OR;
      repeat (2) tick();
      bus.in_valid = 1'b0;
      chk("full_pre_rst", 64'({bus.out_valid, bus.in_ready}), 64'b10);
      #3 sys_rst = 1'b1;
      #2;
      chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("arst_out_y", 64'(bus.out_y), 64'd0);
      chk("arst_zero", 64'(bus.out_zero), 64'd1);
      chk("arst_op_count", 64'(bus.op_count), 64'd0);
      tick();
      sys_rst = 1'b0;
      chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
      bus.out_ready = 1'b1;
      tick();
      chk("arst_flushed", 64'(bus.out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
